// File: rtl/count_display_pkg.sv
// count_display_pkg
//   Shared constants and the hex-to-7-segment glyph decoder for count_display.
//   Ports: none (package).
package count_display_pkg;

  // Digit enables are active-low: exactly one digit is driven at a time.
  localparam logic [1:0] DIG_LO    = 2'b10;
  localparam logic [1:0] DIG_HI    = 2'b01;
  localparam logic [6:0] SEG_RESET = 7'h3F;

  // Active-high segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex2seg(input logic [3:0] val);
    logic [6:0] glyph;
    case (val)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/count_display_sync_chain.sv
// sync_chain
//   Multi-flop synchronizer for a WIDTH-bit bundle of asynchronous inputs.
//   Ports:
//     cp   - system clock
//     clr  - asynchronous active-low reset, loads RST_VAL into every stage
//     d    - asynchronous input
//     q    - synchronized output (last stage)
module sync_chain #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             cp,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/count_display.sv
// count_display
//   Cascades a 4-bit up/down counter into a second (high) hex digit and
//   drives both digits onto a time-multiplexed two-digit 7-segment display.
//   Ports:
//     cp      - system clock, rising edge
//     clr     - asynchronous active-low reset
//     qin     - counter value, shown as the low digit (asynchronous)
//     qcc_in  - counter carry/borrow, active-low, idles high (asynchronous)
//     m_in    - counter direction, 1 = up, 0 = down (asynchronous)
//     hclr_n  - active-low clear of the high digit (asynchronous, level)
//     hi      - high digit
//     ovf     - one-cycle pulse when hi wraps
//     seg     - active-high segments, seg[0] = a ... seg[6] = g
//     dig     - active-low digit enables, dig[0] = low, dig[1] = high
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       cp,
  input  logic       clr,
  input  logic [3:0] qin,
  input  logic       qcc_in,
  input  logic       m_in,
  input  logic       hclr_n,
  output logic [3:0] hi,
  output logic       ovf,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]       qin_sync;
  logic             m_sync;
  logic             qcc_sync;
  logic             hclr_sync;
  logic             qcc_prev;
  logic             carry_evt;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             sel;

  sync_chain #(.WIDTH(4), .STAGES(SYNC_STAGES), .RST_VAL(4'h0)) u_sync_qin (
    .cp(cp), .clr(clr), .d(qin), .q(qin_sync)
  );

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_m (
    .cp(cp), .clr(clr), .d(m_in), .q(m_sync)
  );

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_qcc (
    .cp(cp), .clr(clr), .d(qcc_in), .q(qcc_sync)
  );

  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_hclr (
    .cp(cp), .clr(clr), .d(hclr_n), .q(hclr_sync)
  );

  // Falling edge of the synchronized carry. qcc_prev resets high so that
  // leaving reset with the carry idle never looks like an edge, and a held
  // carry yields a single event.
  assign carry_evt = qcc_prev & ~qcc_sync;

  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      qcc_prev <= 1'b1;
      hi       <= 4'h0;
      ovf      <= 1'b0;
    end else begin
      qcc_prev <= qcc_sync;
      if (!hclr_sync) begin
        hi  <= 4'h0;
        ovf <= 1'b0;
      end else if (carry_evt && m_sync) begin
        hi  <= hi + 4'h1;
        ovf <= (hi == 4'hF);
      end else if (carry_evt) begin
        hi  <= hi - 4'h1;
        ovf <= (hi == 4'h0);
      end else begin
        ovf <= 1'b0;
      end
    end
  end

  assign tick = (div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      div <= '0;
      sel <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) sel <= ~sel;
    end
  end

  // seg and dig are registered from the same sel, so they always switch on
  // the same edge and a digit never shows the other digit's glyph.
  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      seg <= SEG_RESET;
      dig <= DIG_LO;
    end else begin
      seg <= hex2seg(sel ? hi : qin_sync);
      dig <= sel ? DIG_HI : DIG_LO;
    end
  end

endmodule

// File: tb/tb_count_display.sv
module tb_count_display;

  logic       cp;
  logic       clr;
  logic [3:0] qin;
  logic       qcc_in;
  logic       m_in;
  logic       hclr_n;
  logic [3:0] hi;
  logic       ovf;
  logic [6:0] seg;
  logic [1:0] dig;

  int n_checks = 0;
  int n_pass   = 0;

  count_display #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
    .cp(cp), .clr(clr), .qin(qin), .qcc_in(qcc_in), .m_in(m_in),
    .hclr_n(hclr_n), .hi(hi), .ovf(ovf), .seg(seg), .dig(dig)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Low pulse on qcc_in of n_low cycles (n_low >= 4). hi must hold for two
  // edges, move to new_hi on the third, and ovf must pulse for one cycle only.
  task automatic carry_pulse(input int n_low, input logic [3:0] old_hi,
                             input logic [3:0] new_hi, input logic exp_ovf);
    @(negedge cp) qcc_in = 1'b0;
    @(negedge cp) check("hold_e1", hi, old_hi);
    @(negedge cp) check("hold_e2", hi, old_hi);
    check("ovf_e2", ovf, 0);
    @(negedge cp) check("hi_e3", hi, new_hi);
    check("ovf_e3", ovf, exp_ovf);
    for (int i = 3; i < n_low; i++) begin
      @(negedge cp);
      if (i == 3) check("ovf_e4", ovf, 0);
    end
    qcc_in = 1'b1;
    repeat (4) @(negedge cp);
    check("hi_after", hi, new_hi);
    check("ovf_after", ovf, 0);
  endtask

  task automatic set_dir(input logic m);
    @(negedge cp) m_in = m;
    repeat (3) @(negedge cp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] prev_dig;
    int         run;
    bit         seen_change;

    clr = 1'b0; qin = 4'h0; qcc_in = 1'b1; m_in = 1'b1; hclr_n = 1'b1;
    repeat (3) @(negedge cp);
    check("rst_hi", hi, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dig", dig, 2'b10);
    check("rst_seg", seg, 7'h3F);
    clr = 1'b1;
    repeat (6) @(negedge cp);
    check("rel_hi", hi, 0);
    check("rel_ovf", ovf, 0);

    // Down borrow: 0 -> F with ovf, then F -> E without.
    set_dir(1'b0);
    carry_pulse(4, 4'h0, 4'hF, 1'b1);
    carry_pulse(4, 4'hF, 4'hE, 1'b0);

    // Up carry: E -> F, then F -> 0 with ovf.
    set_dir(1'b1);
    carry_pulse(4, 4'hE, 4'hF, 1'b0);
    carry_pulse(4, 4'hF, 4'h0, 1'b1);

    // Held carry: 100 low cycles give one step, a fresh fall gives another.
    carry_pulse(100, 4'h0, 4'h1, 1'b0);
    carry_pulse(4, 4'h1, 4'h2, 1'b0);

    for (int v = 2; v < 7; v++) carry_pulse(4, 4'(v), 4'(v + 1), 1'b0);

    // Clear and carry event land in the same cycle with hi = 7.
    @(negedge cp) begin hclr_n = 1'b0; qcc_in = 1'b0; end
    @(negedge cp) check("clr_e1", hi, 7);
    @(negedge cp) check("clr_e2", hi, 7);
    @(negedge cp) check("clr_hi", hi, 0);
    check("clr_ovf", ovf, 0);
    @(negedge cp) begin hclr_n = 1'b1; qcc_in = 1'b1; end
    repeat (5) @(negedge cp);
    check("clr_hold", hi, 0);

    for (int v = 0; v < 3; v++) carry_pulse(4, 4'(v), 4'(v + 1), 1'b0);

    // Scan: low digit A, high digit 3.
    @(negedge cp) qin = 4'hA;
    repeat (10) @(negedge cp);
    prev_dig    = dig;
    run         = 1;
    seen_change = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge cp);
      check("dig_nz", dig != 2'b00, 1);
      check("dig_onehot", (dig == 2'b10) || (dig == 2'b01), 1);
      check("scan_seg", seg, (dig == 2'b10) ? 7'h77 : 7'h4F);
      if (dig != prev_dig) begin
        if (seen_change) check("scan_run", run, 4);
        seen_change = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_dig = dig;
    end
    check("scan_toggled", seen_change, 1);

    // Reset while a carry event is in flight.
    @(negedge cp) qcc_in = 1'b0;
    repeat (2) @(negedge cp);
    #2 clr = 1'b0;
    #1;
    check("mid_hi", hi, 0);
    check("mid_ovf", ovf, 0);
    check("mid_dig", dig, 2'b10);
    check("mid_seg", seg, 7'h3F);
    qcc_in = 1'b1;
    repeat (3) @(negedge cp);
    clr = 1'b1;
    repeat (6) @(negedge cp);
    check("mid_rel_hi", hi, 0);
    check("mid_rel_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
